alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 16-bit ALU core between NUM_REQ requesters using round-robin arbitration.
//  - Operand/opcode requests arrive over a valid/ready handshake.
//  - Results come back with zero/negative flags over a valid/ready handshake.
//  - Sits between the instruction-issue units and the single shared ALU datapath.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8)
//  DATA_W   16  operand/result width
// PORTS
//  clk        in   1                clock, all state on rising edge
//  rst_n      in   1                asynchronous active-low reset
//  req_valid  in   NUM_REQ          per-requester request valid
//  req_ready  out  NUM_REQ          per-requester accept, one-hot or zero
//  req_a      in   NUM_REQ*DATA_W   operand A, requester i at [i*DATA_W +: DATA_W]
//  req_b      in   NUM_REQ*DATA_W   operand B, same packing
//  req_c      in   NUM_REQ          carry/borrow in
//  req_op     in   NUM_REQ*3        opcode, requester i at [i*3 +: 3]
//  rsp_valid  out  1                result valid
//  rsp_ready  in   1                result consumed
//  rsp_id     out  $clog2(NUM_REQ)  index of requester owning the result
//  rsp_w      out  DATA_W           ALU result
//  rsp_zero   out  1                rsp_w == 0
//  rsp_neg    out  1                rsp_w[DATA_W-1]
// BEHAVIOUR
//  - Opcodes: 000 ADD A+B+C | 001 SUB A-B-C | 010 AND | 011 OR | 100 XOR | 101 NOT A |
//    110 SHL A by 1, C shifted into LSB | 111 PASS B.
//  - All arithmetic is mod 2^DATA_W; carry-out is discarded.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE:
//    - req_ready[k] is asserted combinationally for winner k only.
//    - k is the first i with req_valid[i]=1, scanning from rr_ptr upward and wrapping at NUM_REQ.
//    - On the handshake: latch a/b/c/op of k and rsp_id<=k, set rr_ptr<=(k+1)%NUM_REQ, go to EXEC.
//    - If no valid is asserted, stay in IDLE and leave rr_ptr unchanged.
//  - EXEC:
//    - Register the ALU output from the latched operands into rsp_w/rsp_zero/rsp_neg.
//    - req_ready is all zero. Go to RESP.
//  - RESP:
//    - rsp_valid=1 and rsp_* are held stable. req_ready is all zero.
//    - On rsp_ready=1: go to IDLE; rsp_valid falls in the next cycle.
//  - Latency: accept edge at cycle N gives rsp_valid high in cycle N+2.
//    Peak throughput is 1 op per 3 cycles.
//  - rsp_ready held low stalls in RESP indefinitely; no new request is accepted.
//  - A requester dropping valid before acceptance is harmless; it simply loses that arbitration.
//  - Reset, from any state including mid-EXEC/RESP:
//    - state IDLE, rr_ptr 0, rsp_valid 0, rsp_id 0, rsp_w 0, rsp_zero 0, rsp_neg 0.
//    - In-flight op is dropped with no response.
//  - req_ready is all zero while rst_n is low.
// CONFIGURATION
//  - ALU_ARB_STATS_EN defined:
//    - Adds output done_count[15:0], reset to 0.
//    - Increments on each rsp_valid&&rsp_ready and wraps 0xFFFF->0x0000.
//  - ALU_ARB_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package alu_arb_pkg:
//    - alu_op_e 3-bit enum: ADD,SUB,AND,OR,XOR,NOTA,SHL,PASSB.
//    - arb_state_e enum: IDLE,EXEC,RESP.
//    - localparam OP_W=3.
//  - Sub-module alu16_core: purely combinational (a,b,c,op -> w,zero,neg), parameterised by DATA_W.
//  - Arbiter, FSM and registers live in the top module.
// TESTING
//  1. Reset with req_valid=0.
//     -> All outputs 0. Raise req_valid=2'b11 while rst_n=0: req_ready stays 00.
//  2. Req0 ADD A=0x0001 B=0x0002 C=1.
//     -> rsp_valid 2 cycles after accept; rsp_w=0x0004, zero=0, neg=0, rsp_id=0.
//  3. Req1 SUB A=0x0005 B=0x0005 C=0 -> rsp_w=0x0000, zero=1.
//     Then Req1 SUB A=0x0000 B=0x0001 C=0 -> rsp_w=0xFFFF, neg=1.
//  4. req_valid=2'b11 held, rsp_ready=1.
//     -> Grants alternate 0,1,0,1,...; an accept every 3rd cycle.
//  5. rsp_ready=0 for 5 cycles in RESP.
//     -> rsp_* stable, req_ready=00. Raise rsp_ready: IDLE next cycle, next accept follows.
//  6. Assert rst_n=0 during EXEC.
//     -> No rsp_valid afterwards, rr_ptr=0 (next grant to req0); with ALU_ARB_STATS_EN, done_count=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types for the round-robin shared-ALU arbiter: opcode and FSM state encodings.
package alu_arb_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    AND   = 3'b010,
    OR    = 3'b011,
    XOR   = 3'b100,
    NOTA  = 3'b101,
    SHL   = 3'b110,
    PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu16_core.sv
// Combinational ALU datapath shared by all requesters; result wraps mod 2^DATA_W.
module alu16_core
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] w,
  output logic              zero,
  output logic              neg
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] c_s;

  assign a_s = a;
  assign b_s = b;
  assign c_s = {{(DATA_W-1){1'b0}}, c};

  always_comb begin
    w = '0;
    case (op)
      ADD:   w = a_s + b_s + c_s;
      SUB:   w = a_s - b_s - c_s;
      AND:   w = a & b;
      OR:    w = a | b;
      XOR:   w = a ^ b;
      NOTA:  w = ~a;
      SHL:   w = {a[DATA_W-2:0], c};
      PASSB: w = b;
      default: w = '0;
    endcase
  end

  assign zero = (w == '0);
  assign neg  = w[DATA_W-1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Optional ALU_ARB_STATS_EN adds a wrapping done_count of completed responses.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_c,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_w,
  output logic                      rsp_zero,
  output logic                      rsp_neg
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]               done_count
`endif
);

  arb_state_e          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     rr_nxt;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     off_sel;
  logic [ID_W:0]       idx_sum;
  logic                grant_found;
  logic                accept;
  logic [2*NUM_REQ-1:0] vld_dbl;
  logic [NUM_REQ-1:0]  vld_rot;

  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic                c_p0;
  alu_op_e             op_p0;

  logic [DATA_W-1:0]   alu_w;
  logic                alu_zero;
  logic                alu_neg;

  // Rotate valids so bit 0 is the requester at rr_ptr; lowest set bit wins.
  assign vld_dbl = {req_valid, req_valid} >> rr_ptr;
  assign vld_rot = vld_dbl[NUM_REQ-1:0];

  always_comb begin
    grant_found = 1'b0;
    off_sel     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (vld_rot[off]) begin
        grant_found = 1'b1;
        off_sel     = ID_W'(off);
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, rr_ptr} + {1'b0, off_sel};
    if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
      idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
    end
    grant_idx = idx_sum[ID_W-1:0];
  end

  assign rr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |req_ready;

  // Stage p0: operands of the granted requester, captured on the accept edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      a_p0  <= req_a[grant_idx*DATA_W +: DATA_W];
      b_p0  <= req_b[grant_idx*DATA_W +: DATA_W];
      c_p0  <= req_c[grant_idx];
      op_p0 <= alu_op_e'(req_op[grant_idx*OP_W +: OP_W]);
    end
  end

  alu16_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .a    (a_p0),
    .b    (b_p0),
    .c    (c_p0),
    .op   (op_p0),
    .w    (alu_w),
    .zero (alu_zero),
    .neg  (alu_neg)
  );

  // Stage p1: registered ALU result held in RESP until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_w     <= '0;
      rsp_zero  <= 1'b0;
      rsp_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= grant_idx;
            rr_ptr <= rr_nxt;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_w     <= alu_w;
          rsp_zero  <= alu_zero;
          rsp_neg   <= alu_neg;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      done_count <= done_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter against a behavioural ALU/round-robin model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_c;
  logic [5:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_w;
  logic        rsp_zero;
  logic        rsp_neg;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] done_count;
`endif

  logic [15:0] a_v [2];
  logic [15:0] b_v [2];
  logic        c_v [2];
  logic [2:0]  op_v [2];

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int done_exp = 0;
  logic exp_ptr;

  assign req_a  = {a_v[1], a_v[0]};
  assign req_b  = {b_v[1], b_v[0]};
  assign req_c  = {c_v[1], c_v[0]};
  assign req_op = {op_v[1], op_v[0]};

  alu_share_arbiter #(.NUM_REQ(2), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_w     (rsp_w),
    .rsp_zero  (rsp_zero),
    .rsp_neg   (rsp_neg)
`ifdef ALU_ARB_STATS_EN
    ,
    .done_count(done_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n && ((req_valid & req_ready) != 2'b00)) acc_cnt++;
  end

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'd0: r = 32'(a) + 32'(b) + 32'(c);
      3'd1: r = 32'(a) - 32'(b) - 32'(c);
      3'd2: r = 32'(a & b);
      3'd3: r = 32'(a | b);
      3'd4: r = 32'(a ^ b);
      3'd5: r = 32'(~a);
      3'd6: r = 32'(a) * 2 + 32'(c);
      default: r = 32'(b);
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic w, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [2:0] op);
    a_v[w] = a; b_v[w] = b; c_v[w] = c; op_v[w] = op;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 2; i++) begin
      a_v[i]  = 16'($urandom);
      b_v[i]  = 16'($urandom);
      c_v[i]  = 1'($urandom);
      op_v[i] = 3'($urandom);
    end
  endtask

  // Called at posedge+1 with the DUT idle; runs one full request/response exchange.
  task automatic txn(input logic [1:0] vmask, input int stall);
    logic        w;
    logic [15:0] ew;
    w  = vmask[exp_ptr] ? exp_ptr : ~exp_ptr;
    ew = alu_ref(a_v[w], b_v[w], c_v[w], op_v[w]);
    req_valid = vmask;
    rsp_ready = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 32'(2'b01 << w));
    @(posedge clk); #1;
    chk("exec_valid", 32'(rsp_valid), 32'd0);
    chk("exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(w));
    chk("rsp_w", 32'(rsp_w), 32'(ew));
    chk("rsp_zero", 32'(rsp_zero), 32'(ew == 16'h0000));
    chk("rsp_neg", 32'(rsp_neg), 32'(ew[15]));
    chk("resp_ready", 32'(req_ready), 32'd0);
    if (stall > 0) begin
      rsp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_w", 32'(rsp_w), 32'(ew));
        chk("stall_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    exp_ptr = ~w;
    done_exp++;
`ifdef ALU_ARB_STATS_EN
    chk("done_count", 32'(done_count), 32'(done_exp));
`endif
  endtask

  initial begin
    int acc0;
    rst_n = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    exp_ptr = 1'b0;
    randomize_ops();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;

    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_w", 32'(rsp_w), 32'd0);
    chk("rst_flags", 32'({rsp_zero, rsp_neg}), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_done", 32'(done_count), 32'd0);
`endif
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_op(1'b0, 16'h0001, 16'h0002, 1'b1, 3'd0);
    txn(2'b01, 0);

    set_op(1'b1, 16'h0005, 16'h0005, 1'b0, 3'd1);
    txn(2'b10, 0);
    set_op(1'b1, 16'h0000, 16'h0001, 1'b0, 3'd1);
    txn(2'b10, 0);

    acc0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      randomize_ops();
      txn(2'b11, 0);
    end
    chk("throughput", 32'(acc_cnt - acc0), 32'd6);

    randomize_ops();
    txn(2'b11, 5);
    randomize_ops();
    txn(2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      randomize_ops();
      txn(2'(1 + $urandom_range(0, 2)), $urandom_range(0, 2));
    end

    req_valid = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_w", 32'(rsp_w), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("mid_rst_done", 32'(done_count), 32'd0);
`endif
    done_exp = 0;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    end
    exp_ptr = 1'b0;
    randomize_ops();
    txn(2'b11, 0);
    randomize_ops();
    txn(2'b11, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
